// File: rtl/beer_pkg.sv
// Shared lane constants, lane FSM state and player/owner encoding for the
// beer lane scheduler.
package beer_pkg;

  localparam int NUM_LANES = 6;
  localparam int Y_TOP     = 125;
  localparam int Y_STEP    = 50;
  localparam int LANE_LEN  = 32;
  localparam int POS_W     = 5;
  localparam int STEP_DIV  = 4;
  localparam int Y_W       = 11;
  localparam int DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {
    LANE_IDLE = 1'b0,
    LANE_FLY  = 1'b1
  } lane_state_e;

  typedef enum logic {
    OWNER_P1 = 1'b0,
    OWNER_P2 = 1'b1
  } owner_e;

  // Player y coordinate that lines up with lane idx.
  function automatic logic [Y_W-1:0] lane_y(input int idx);
    return Y_W'(Y_TOP + idx * Y_STEP);
  endfunction

endpackage

// File: rtl/beer_lane.sv
// One serving lane: IDLE/FLY state, step divider, mug position and owner.
// hit/miss are single-edge events consumed and registered by the top.
module beer_lane
  import beer_pkg::*;
(
  input  logic             CLK_2_21,
  input  logic             RESET,
  input  logic             run,
  input  logic             start,
  input  owner_e           start_owner,
  input  logic             catch_pulse,
  output logic             busy,
  output logic             owner,
  output logic [POS_W-1:0] mug_x,
  output logic             hit,
  output logic             miss
);

  lane_state_e      state_reg, state_next;
  owner_e           owner_reg, owner_next;
  logic [POS_W-1:0] mug_x_reg, mug_x_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             step_wrap;

  assign step_wrap = (div_reg == DIV_W'(STEP_DIV - 1));

  always_ff @(posedge CLK_2_21 or posedge RESET) begin
    if (RESET) begin
      state_reg <= LANE_IDLE;
      owner_reg <= OWNER_P1;
      mug_x_reg <= '0;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      mug_x_reg <= mug_x_next;
      div_reg   <= div_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    mug_x_next = mug_x_reg;
    div_next   = div_reg;
    hit        = 1'b0;
    miss       = 1'b0;
    if (!run) begin
      state_next = LANE_IDLE;
      mug_x_next = '0;
      div_next   = '0;
    end else begin
      case (state_reg)
        LANE_IDLE: begin
          if (start) begin
            state_next = LANE_FLY;
            owner_next = start_owner;
            mug_x_next = '0;
            div_next   = '0;
          end
        end
        LANE_FLY: begin
          // A catch takes priority over the mug reaching the lane end.
          if (catch_pulse) begin
            hit        = 1'b1;
            state_next = LANE_IDLE;
            mug_x_next = '0;
            div_next   = '0;
          end else if (step_wrap) begin
            div_next = '0;
            if (mug_x_reg == POS_W'(LANE_LEN - 1)) begin
              miss       = 1'b1;
              state_next = LANE_IDLE;
              mug_x_next = '0;
            end else begin
              mug_x_next = mug_x_reg + POS_W'(1);
            end
          end else begin
            div_next = div_reg + DIV_W'(1);
          end
        end
        default: state_next = LANE_IDLE;
      endcase
    end
  end

  assign busy  = (state_reg == LANE_FLY);
  assign owner = owner_reg;
  assign mug_x = mug_x_reg;

endmodule

// File: rtl/beer_lane_scheduler.sv
// Maps player y positions to lanes, round-robin arbitrates throws onto idle
// lanes and folds per-lane catch/fall events into registered player pulses.
module beer_lane_scheduler
  import beer_pkg::*;
(
  input  logic                       CLK_2_21,
  input  logic                       RESET,
  input  logic                       run,
  input  logic [Y_W-1:0]             P1_y,
  input  logic [Y_W-1:0]             P2_y,
  input  logic                       P1_throw,
  input  logic                       P2_throw,
  input  logic [NUM_LANES-1:0]       catch_in,
  output logic [NUM_LANES-1:0]       lane_busy,
  output logic [NUM_LANES-1:0]       lane_owner,
  output logic [NUM_LANES*POS_W-1:0] mug_x,
  output logic                       P1_grant,
  output logic                       P2_grant,
  output logic                       P1_hit,
  output logic                       P2_hit,
  output logic                       P1_miss,
  output logic                       P2_miss
);

  logic [NUM_LANES-1:0] p1_sel, p2_sel;
  logic [NUM_LANES-1:0] p1_start, p2_start;
  logic [NUM_LANES-1:0] lane_hit, lane_miss;
  logic                 p1_ok, p2_ok, contested, p1_win, p2_win;
  owner_e               rr_reg, rr_next;

  // Selects are one-hot or empty, so an off-grid y simply never matches.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign p1_sel[gi]   = P1_throw && (P1_y == lane_y(gi));
      assign p2_sel[gi]   = P2_throw && (P2_y == lane_y(gi));
      assign p1_start[gi] = p1_win && p1_sel[gi];
      assign p2_start[gi] = p2_win && p2_sel[gi];

      beer_lane u_lane (
        .CLK_2_21    (CLK_2_21),
        .RESET       (RESET),
        .run         (run),
        .start       (p1_start[gi] | p2_start[gi]),
        .start_owner (p2_start[gi] ? OWNER_P2 : OWNER_P1),
        .catch_pulse (catch_in[gi]),
        .busy        (lane_busy[gi]),
        .owner       (lane_owner[gi]),
        .mug_x       (mug_x[gi*POS_W +: POS_W]),
        .hit         (lane_hit[gi]),
        .miss        (lane_miss[gi])
      );
    end
  endgenerate

  // Only lanes idle in the registered state are eligible targets.
  assign p1_ok     = run && |(p1_sel & ~lane_busy);
  assign p2_ok     = run && |(p2_sel & ~lane_busy);
  assign contested = p1_ok && p2_ok && (p1_sel == p2_sel);
  assign p1_win    = p1_ok && (!contested || rr_reg == OWNER_P1);
  assign p2_win    = p2_ok && (!contested || rr_reg == OWNER_P2);

  always_comb begin
    rr_next = rr_reg;
    if (contested) begin
      rr_next = (rr_reg == OWNER_P1) ? OWNER_P2 : OWNER_P1;
    end
  end

  always_ff @(posedge CLK_2_21 or posedge RESET) begin
    if (RESET) begin
      rr_reg   <= OWNER_P1;
      P1_grant <= 1'b0;
      P2_grant <= 1'b0;
      P1_hit   <= 1'b0;
      P2_hit   <= 1'b0;
      P1_miss  <= 1'b0;
      P2_miss  <= 1'b0;
    end else begin
      rr_reg   <= rr_next;
      P1_grant <= p1_win;
      P2_grant <= p2_win;
      P1_hit   <= |(lane_hit & ~lane_owner);
      P2_hit   <= |(lane_hit & lane_owner);
      P1_miss  <= |(lane_miss & ~lane_owner);
      P2_miss  <= |(lane_miss & lane_owner);
    end
  end

endmodule

// File: tb/tb_beer_lane_scheduler.sv
// Self-checking bench for beer_lane_scheduler: directed scenarios plus a
// randomized run against a flight-age reference model.
`timescale 1ns/1ps
module tb_beer_lane_scheduler;
  import beer_pkg::*;

  localparam int FLIGHT = LANE_LEN * STEP_DIV;
  localparam int VW     = 3 * NUM_LANES + NUM_LANES * POS_W + 6;

  logic                       CLK_2_21 = 1'b0;
  logic                       RESET;
  logic                       run;
  logic [Y_W-1:0]             P1_y, P2_y;
  logic                       P1_throw, P2_throw;
  logic [NUM_LANES-1:0]       catch_in;
  logic [NUM_LANES-1:0]       lane_busy, lane_owner;
  logic [NUM_LANES*POS_W-1:0] mug_x;
  logic                       P1_grant, P2_grant, P1_hit, P2_hit, P1_miss, P2_miss;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a lane is a flag, an owner and the edges since launch.
  bit m_busy  [NUM_LANES];
  bit m_owner [NUM_LANES];
  int m_age   [NUM_LANES];
  bit m_rr;
  bit e_g1, e_g2, e_h1, e_h2, e_m1, e_m2;

  always #5 CLK_2_21 = ~CLK_2_21;

  beer_lane_scheduler dut (
    .CLK_2_21   (CLK_2_21),
    .RESET      (RESET),
    .run        (run),
    .P1_y       (P1_y),
    .P2_y       (P2_y),
    .P1_throw   (P1_throw),
    .P2_throw   (P2_throw),
    .catch_in   (catch_in),
    .lane_busy  (lane_busy),
    .lane_owner (lane_owner),
    .mug_x      (mug_x),
    .P1_grant   (P1_grant),
    .P2_grant   (P2_grant),
    .P1_hit     (P1_hit),
    .P2_hit     (P2_hit),
    .P1_miss    (P1_miss),
    .P2_miss    (P2_miss)
  );

  function automatic int y2lane(input logic [Y_W-1:0] y);
    int v;
    v = int'(y);
    if (v < Y_TOP) return -1;
    if ((v - Y_TOP) % Y_STEP != 0) return -1;
    if ((v - Y_TOP) / Y_STEP >= NUM_LANES) return -1;
    return (v - Y_TOP) / Y_STEP;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LANES; i++) begin
      m_busy[i] = 0; m_owner[i] = 0; m_age[i] = 0;
    end
    m_rr = 0;
    {e_g1, e_g2, e_h1, e_h2, e_m1, e_m2} = '0;
  endtask

  task automatic model_edge();
    bit old_busy [NUM_LANES];
    int l1, l2;
    {e_g1, e_g2, e_h1, e_h2, e_m1, e_m2} = '0;
    if (RESET) begin
      model_reset();
      return;
    end
    if (!run) begin
      for (int i = 0; i < NUM_LANES; i++) begin m_busy[i] = 0; m_age[i] = 0; end
      return;
    end
    old_busy = m_busy;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (m_busy[i]) begin
        if (catch_in[i]) begin
          m_busy[i] = 0;
          if (m_owner[i]) e_h2 = 1; else e_h1 = 1;
        end else begin
          m_age[i]++;
          if (m_age[i] == FLIGHT) begin
            m_busy[i] = 0;
            if (m_owner[i]) e_m2 = 1; else e_m1 = 1;
          end
        end
      end
    end
    l1 = P1_throw ? y2lane(P1_y) : -1;
    l2 = P2_throw ? y2lane(P2_y) : -1;
    if (l1 >= 0 && old_busy[l1]) l1 = -1;
    if (l2 >= 0 && old_busy[l2]) l2 = -1;
    if (l1 >= 0 && l1 == l2) begin
      if (m_rr) l1 = -1; else l2 = -1;
      m_rr = !m_rr;
    end
    if (l1 >= 0) begin m_busy[l1] = 1; m_owner[l1] = 0; m_age[l1] = 0; e_g1 = 1; end
    if (l2 >= 0) begin m_busy[l2] = 1; m_owner[l2] = 1; m_age[l2] = 0; e_g2 = 1; end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NUM_LANES-1:0]       b, o;
    logic [NUM_LANES*POS_W-1:0] x;
    for (int i = 0; i < NUM_LANES; i++) begin
      b[i] = m_busy[i];
      o[i] = m_busy[i] & m_owner[i];
      x[i*POS_W +: POS_W] = m_busy[i] ? POS_W'(m_age[i] / STEP_DIV) : '0;
    end
    return {b, o, x, e_g1, e_g2, e_h1, e_h2, e_m1, e_m2};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {lane_busy, lane_owner & lane_busy, mug_x,
            P1_grant, P2_grant, P1_hit, P2_hit, P1_miss, P2_miss};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge CLK_2_21);
    #1;
  endtask

  task automatic idle_inputs();
    P1_throw = 0; P2_throw = 0; catch_in = '0;
  endtask

  task automatic test_reset();
    RESET = 1; run = 0; P1_y = '0; P2_y = '0;
    idle_inputs();
    model_reset();
    @(posedge CLK_2_21); #1;
    n_checks++;
    if (dut_vec() !== '0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", dut_vec()); end
    RESET = 0;
    tick();
    n_checks++;
    if (dut_vec() !== '0) begin n_fail++; $display("FAIL reset_release: got %h want 0", dut_vec()); end
    $display("reset: outputs idle");
  endtask

  task automatic test_single_miss();
    run = 1; P1_y = 11'd125; P1_throw = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_grant, lane_busy[0], lane_owner[0], mug_x[POS_W-1:0]} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL single_launch: grant=%b busy0=%b owner0=%b x0=%0d want 1 1 0 0",
               P1_grant, lane_busy[0], lane_owner[0], mug_x[POS_W-1:0]);
    end
    tick();
    n_checks++;
    if (P1_grant !== 1'b0) begin n_fail++; $display("FAIL grant_pulse_width: got %b want 0", P1_grant); end
    repeat (FLIGHT - 2) tick();
    n_checks++;
    if ({lane_busy[0], P1_miss, mug_x[POS_W-1:0]} !== {1'b1, 1'b0, 5'd31}) begin
      n_fail++;
      $display("FAIL pre_end: busy0=%b miss=%b x0=%0d want 1 0 31", lane_busy[0], P1_miss, mug_x[POS_W-1:0]);
    end
    tick();
    n_checks++;
    if ({P1_miss, lane_busy[0], mug_x[POS_W-1:0]} !== {1'b1, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL lane_end_miss: miss=%b busy0=%b x0=%0d want 1 0 0", P1_miss, lane_busy[0], mug_x[POS_W-1:0]);
    end
    tick();
    n_checks++;
    if (P1_miss !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width: got %b want 0", P1_miss); end
    $display("single: P1 lane 0 launched, fell after %0d edges", FLIGHT);
  endtask

  task automatic test_contested();
    P1_y = 11'd225; P2_y = 11'd225; P1_throw = 1; P2_throw = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_grant, P2_grant, lane_busy[2], lane_owner[2]} !== 4'b1010) begin
      n_fail++;
      $display("FAIL contest_first: g1=%b g2=%b busy2=%b owner2=%b want 1 0 1 0",
               P1_grant, P2_grant, lane_busy[2], lane_owner[2]);
    end
    catch_in[2] = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_hit, P2_hit, lane_busy[2]} !== 3'b100) begin
      n_fail++;
      $display("FAIL contest_catch1: h1=%b h2=%b busy2=%b want 1 0 0", P1_hit, P2_hit, lane_busy[2]);
    end
    P1_throw = 1; P2_throw = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_grant, P2_grant, lane_busy[2], lane_owner[2]} !== 4'b0111) begin
      n_fail++;
      $display("FAIL contest_second: g1=%b g2=%b busy2=%b owner2=%b want 0 1 1 1",
               P1_grant, P2_grant, lane_busy[2], lane_owner[2]);
    end
    catch_in[2] = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_hit, P2_hit} !== 2'b01) begin
      n_fail++;
      $display("FAIL contest_catch2: h1=%b h2=%b want 0 1", P1_hit, P2_hit);
    end
    $display("contest: lane 2 to P1 then P2");
  endtask

  task automatic test_catch_at_end();
    P2_y = 11'd175; P2_throw = 1;
    tick();
    idle_inputs();
    repeat (FLIGHT - 1) tick();
    catch_in[1] = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P2_hit, P2_miss, lane_busy[1]} !== 3'b100) begin
      n_fail++;
      $display("FAIL catch_at_end: hit=%b miss=%b busy1=%b want 1 0 0", P2_hit, P2_miss, lane_busy[1]);
    end
    tick();
    n_checks++;
    if ({P2_hit, P2_miss} !== 2'b00) begin
      n_fail++;
      $display("FAIL catch_at_end_after: hit=%b miss=%b want 0 0", P2_hit, P2_miss);
    end
    $display("catch_at_end: P2 lane 1 caught on final step");
  endtask

  task automatic test_invalid_and_busy();
    P1_y = 11'd130; P1_throw = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_grant, lane_busy} !== {1'b0, 6'b000000}) begin
      n_fail++;
      $display("FAIL invalid_y: grant=%b busy=%b want 0 000000", P1_grant, lane_busy);
    end
    P2_y = 11'd275; P2_throw = 1;
    tick();
    idle_inputs();
    P1_y = 11'd275; P1_throw = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_grant, lane_busy, lane_owner[3]} !== {1'b0, 6'b001000, 1'b1}) begin
      n_fail++;
      $display("FAIL throw_to_busy: grant=%b busy=%b owner3=%b want 0 001000 1", P1_grant, lane_busy, lane_owner[3]);
    end
    catch_in[3] = 1;
    tick();
    idle_inputs();
    $display("invalid/busy: off-grid and busy-lane throws dropped");
  endtask

  task automatic test_run_drop();
    P1_y = 11'd125; P2_y = 11'd375; P1_throw = 1; P2_throw = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P1_grant, P2_grant, lane_busy} !== {2'b11, 6'b100001}) begin
      n_fail++;
      $display("FAIL dual_grant: g1=%b g2=%b busy=%b want 1 1 100001", P1_grant, P2_grant, lane_busy);
    end
    repeat (5) tick();
    run = 0;
    tick();
    n_checks++;
    if (dut_vec() !== '0) begin n_fail++; $display("FAIL run_drop: got %h want 0", dut_vec()); end
    P2_throw = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({P2_grant, lane_busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL throw_while_stopped: g2=%b busy=%b want 0 000000", P2_grant, lane_busy);
    end
    run = 1;
    $display("run_drop: lanes cleared without pulses");
  endtask

  task automatic test_async_reset();
    P1_y = 11'd125; P1_throw = 1;
    tick();
    idle_inputs();
    repeat (10) tick();
    n_checks++;
    if (lane_busy[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", lane_busy[0]); end
    #2 RESET = 1;
    #1;
    n_checks++;
    if (dut_vec() !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", dut_vec()); end
    model_reset();
    @(posedge CLK_2_21); #1;
    RESET = 0;
    $display("async_reset: outputs cleared mid-cycle");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 4000; c++) begin
      run = ($urandom_range(0, 299) != 0);
      P1_y = ($urandom_range(0, 9) < 8) ? 11'(Y_TOP + Y_STEP * int'($urandom_range(0, NUM_LANES - 1)))
                                        : 11'($urandom_range(0, 2047));
      P2_y = ($urandom_range(0, 2) == 0) ? P1_y
           : 11'(Y_TOP + Y_STEP * int'($urandom_range(0, NUM_LANES - 1)));
      P1_throw = ($urandom_range(0, 2) == 0);
      P2_throw = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NUM_LANES; i++) catch_in[i] = ($urandom_range(0, 199) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        bad++;
        if (bad <= 10) $display("FAIL random_cycle_%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (e_g1 || e_g2) $display("random %0d: grant P1=%b P2=%b busy=%b", c, e_g1, e_g2, lane_busy);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_contested();
    test_catch_at_end();
    test_invalid_and_busy();
    test_run_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
